// File: rtl/mesi_isc_breq_arbiter.sv
// Round-robin arbiter that moves head entries from the four per-CPU breq FIFOs
// into the shared broadcast FIFO, tagging each with the CPU ID and a broadcast ID.
module mesi_isc_breq_arbiter #(
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5,
  parameter int BREQ_TAG_WIDTH   = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    breq_fifo_empty_array_i,
  input  logic [4*BROAD_TYPE_WIDTH-1:0] breq_type_array_i,
  input  logic [4*BREQ_TAG_WIDTH-1:0]   breq_tag_array_i,
  input  logic                          broad_fifo_full_i,
  output logic [3:0]                    breq_fifo_rd_array_o,
  output logic                          broad_fifo_wr_o,
  output logic [BROAD_TYPE_WIDTH-1:0]   broad_type_o,
  output logic [1:0]                    broad_cpu_id_o,
  output logic [BREQ_TAG_WIDTH-1:0]     broad_tag_o,
  output logic [BROAD_ID_WIDTH-1:0]     broad_id_o,
  output logic [15:0]                   grant_cnt_o
);

  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_NOP = BROAD_TYPE_WIDTH'(0);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RSV = BROAD_TYPE_WIDTH'(3);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t                      state;
  logic [1:0]                  rr_ptr;
  logic [BROAD_ID_WIDTH-1:0]   id_ctr;
  logic [3:0]                  req;
  logic [1:0]                  idx;
  logic [1:0]                  winner;
  logic                        found;
  logic [BROAD_TYPE_WIDTH-1:0] win_type;
  logic [BREQ_TAG_WIDTH-1:0]   win_tag;
  logic                        win_nop;

  assign req = ~breq_fifo_empty_array_i;

  // First requester scanning upward from rr_ptr, wrapping modulo 4.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign win_type = breq_type_array_i[winner*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
  assign win_tag  = breq_tag_array_i[winner*BREQ_TAG_WIDTH +: BREQ_TAG_WIDTH];
  assign win_nop  = (win_type == TYPE_NOP) || (win_type == TYPE_RSV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      rr_ptr               <= 2'd0;
      id_ctr               <= '0;
      breq_fifo_rd_array_o <= 4'd0;
      broad_fifo_wr_o      <= 1'b0;
      broad_type_o         <= '0;
      broad_cpu_id_o       <= 2'd0;
      broad_tag_o          <= '0;
      broad_id_o           <= '0;
      grant_cnt_o          <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          // NOP heads are discarded without needing room downstream.
          if (found && (win_nop || !broad_fifo_full_i)) begin
            breq_fifo_rd_array_o <= 4'b0001 << winner;
            rr_ptr               <= winner + 2'd1;
            state                <= ISSUE;
            if (!win_nop) begin
              broad_fifo_wr_o <= 1'b1;
              broad_type_o    <= win_type;
              broad_cpu_id_o  <= winner;
              broad_tag_o     <= win_tag;
              broad_id_o      <= id_ctr;
              id_ctr          <= id_ctr + 1'b1;
              if (grant_cnt_o != 16'hFFFF)
                grant_cnt_o <= grant_cnt_o + 16'd1;
            end
          end
        end
        ISSUE: begin
          breq_fifo_rd_array_o <= 4'd0;
          broad_fifo_wr_o      <= 1'b0;
          state                <= SETTLE;
        end
        SETTLE: begin
          state <= IDLE;
        end
        default: begin
          breq_fifo_rd_array_o <= 4'd0;
          broad_fifo_wr_o      <= 1'b0;
          state                <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_isc_breq_arbiter.sv
// Randomised bench for mesi_isc_breq_arbiter against a transaction-level model
// of the round-robin grant rules.
module tb_mesi_isc_breq_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  empty = 4'hF;
  logic [7:0]  types = 8'd0;
  logic [19:0] tags = 20'd0;
  logic        full = 1'b0;

  logic [3:0]  rd;
  logic        wr;
  logic [1:0]  b_type;
  logic [1:0]  b_cpu;
  logic [4:0]  b_tag;
  logic [4:0]  b_id;
  logic [15:0] g_cnt;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_rd, m_wr, m_type, m_cpu, m_tag, m_id;
  int m_next_id, m_ptr, m_cnt, m_busy;

  always #5 clk = ~clk;

  mesi_isc_breq_arbiter #(
    .BROAD_TYPE_WIDTH(2),
    .BROAD_ID_WIDTH(5),
    .BREQ_TAG_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .breq_fifo_empty_array_i(empty),
    .breq_type_array_i(types),
    .breq_tag_array_i(tags),
    .broad_fifo_full_i(full),
    .breq_fifo_rd_array_o(rd),
    .broad_fifo_wr_o(wr),
    .broad_type_o(b_type),
    .broad_cpu_id_o(b_cpu),
    .broad_tag_o(b_tag),
    .broad_id_o(b_id),
    .grant_cnt_o(g_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_type = 0; m_cpu = 0; m_tag = 0; m_id = 0;
    m_next_id = 0; m_ptr = 0; m_cnt = 0; m_busy = 0;
  endtask

  // A grant occupies the decision slot plus two dead cycles afterwards.
  task automatic model_edge();
    int w, t;
    m_rd = 0;
    m_wr = 0;
    if (m_busy > 0) begin
      m_busy--;
      return;
    end
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && !empty[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    if (w < 0) return;
    t = int'(types[w*2 +: 2]);
    if (t == 0 || t == 3) begin
      m_rd = 1 << w;
      m_ptr = (w + 1) % 4;
      m_busy = 2;
    end else if (!full) begin
      m_rd = 1 << w;
      m_wr = 1;
      m_type = t;
      m_cpu = w;
      m_tag = int'(tags[w*5 +: 5]);
      m_id = m_next_id;
      m_next_id = (m_next_id + 1) % 32;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      m_ptr = (w + 1) % 4;
      m_busy = 2;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("rd", int'(rd), m_rd);
    check("wr", int'(wr), m_wr);
    check("type", int'(b_type), m_type);
    check("cpu", int'(b_cpu), m_cpu);
    check("tag", int'(b_tag), m_tag);
    check("id", int'(b_id), m_id);
    check("gcnt", int'(g_cnt), m_cnt);
    if (m_rd != 0)
      $display("grant rd=%b wr=%0d cpu=%0d type=%0d tag=%0d id=%0d cnt=%0d",
               rd, wr, b_cpu, b_type, b_tag, b_id, g_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic all_wr();
    empty = 4'h0;
    types = 8'b01_01_01_01;
    for (int k = 0; k < 4; k++) tags[k*5 +: 5] = 5'(k + 10);
    full = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();
    step();
    check("reset_rd", int'(rd), 0);
    check("reset_id", int'(b_id), 0);

    // CPU2 RD request, tag 7
    empty = 4'b1011;
    types = 8'b00_10_00_00;
    tags  = 20'd0;
    tags[10 +: 5] = 5'd7;
    step();
    check("t1_rd", int'(rd), 4);
    check("t1_wr", int'(wr), 1);
    check("t1_cpu", int'(b_cpu), 2);
    check("t1_tag", int'(b_tag), 7);
    empty = 4'hF;
    step();
    step();
    check("t1_idle", int'(rd), 0);

    // Round robin order with every CPU busy
    do_reset();
    all_wr();
    for (int g = 0; g < 5; g++) begin
      step();
      check("rr_cpu", int'(b_cpu), g % 4);
      check("rr_id", int'(b_id), g);
      step();
      step();
    end

    // Full blocks CPU1 RD, then releases it
    do_reset();
    empty = 4'b1101;
    types = 8'b00_00_10_00;
    full  = 1'b1;
    repeat (10) step();
    full = 1'b0;
    step();
    check("full_rel_cpu", int'(b_cpu), 1);
    check("full_rel_wr", int'(wr), 1);
    empty = 4'hF;
    step();
    step();

    // NOP head on CPU3 is dropped even while full
    empty = 4'b0111;
    types = 8'b00_00_00_00;
    full  = 1'b1;
    step();
    check("nop_rd", int'(rd), 8);
    check("nop_wr", int'(wr), 0);
    empty = 4'hF;
    step();
    step();

    // 33 pushes to exercise broadcast ID wrap
    do_reset();
    all_wr();
    repeat (33 * 3) step();
    check("wrap_cnt", int'(g_cnt), 33);
    check("wrap_id", int'(b_id), 0);
    step();

    // Asynchronous reset during ISSUE
    do_reset();
    all_wr();
    empty = 4'b1001;
    step();
    check("pre_rst_wr", int'(wr), 1);
    #2 rst = 1'b0;
    #1;
    check("arst_rd", int'(rd), 0);
    check("arst_wr", int'(wr), 0);
    check("arst_cpu", int'(b_cpu), 0);
    check("arst_cnt", int'(g_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post_rst_cpu", int'(b_cpu), 1);
    check("post_rst_id", int'(b_id), 0);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) empty = 4'($urandom);
      if ($urandom_range(0, 2) == 0) types = 8'($urandom);
      tags = 20'($urandom);
      full = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
